// File: rtl/sha256_msg_padder.sv
// Byte-stream front-end for the SHA-224/256 core: packs bytes big-endian into 512-bit blocks,
// appends 0x80 / zero fill / 64-bit bit length, and issues blocks. Optional: SHA256_PADDER_BLKCNT_EN adds blk_cnt.
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mode,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  input  logic         s_empty,
  input  logic         core_ready,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_digest_valid,
  output logic         msg_done
`ifdef SHA256_PADDER_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  // Handshake: a byte transfers on a rising edge where s_valid && s_ready; s_ready is high only in FILL.
  typedef enum logic [1:0] {S_FILL, S_PAD, S_ISSUE, S_WAIT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_ptr;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_first;
  logic               r_pad_pending;
  logic               r_len_pending;
  logic               r_final;
  logic               r_mode;
  logic               r_init;
  logic               r_next;
  logic               r_done;
  logic [511:0]       r_block;
  logic [511:0]       w_pad_block;
  logic [63:0]        w_len;
  logic               w_accept;
  logic               w_issue;
  logic               w_digest;

  assign s_ready  = (r_state == S_FILL);
  assign w_accept = s_valid && s_ready;
  assign w_issue  = (r_state == S_ISSUE) && core_ready;
  // The digest_valid seen during the pulse cycle is stale from the previous block.
  assign w_digest = (r_state == S_WAIT) && core_digest_valid && !(r_init || r_next);
  assign w_len    = 64'(r_cnt) << 3;

  always_comb begin
    w_pad_block = r_block;
    for (int i = 0; i < 64; i++) begin
      if (6'(i) == r_ptr)     w_pad_block[511-8*i -: 8] = 8'h80;
      else if (6'(i) > r_ptr) w_pad_block[511-8*i -: 8] = 8'h00;
    end
    if (r_ptr <= 6'd55) w_pad_block[63:0] = w_len;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FILL;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (s_last && s_empty)  w_next = S_PAD;
          else if (r_ptr == 6'd63) w_next = S_ISSUE;
          else if (s_last)         w_next = S_PAD;
        end
      end
      S_PAD:   w_next = S_ISSUE;
      S_ISSUE: if (core_ready) w_next = S_WAIT;
      S_WAIT: begin
        if (w_digest) w_next = (r_pad_pending || r_len_pending) ? S_ISSUE : S_FILL;
      end
      default: w_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_first       <= 1'b1;
      r_pad_pending <= 1'b0;
      r_len_pending <= 1'b0;
      r_final       <= 1'b0;
      r_mode        <= 1'b0;
      r_init        <= 1'b0;
      r_next        <= 1'b0;
      r_done        <= 1'b0;
      r_block       <= '0;
    end else begin
      r_init <= 1'b0;
      r_next <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (r_first && r_ptr == 6'd0) r_mode <= mode;
            if (s_last && s_empty) begin
              r_ptr <= '0;
              r_cnt <= '0;
            end else begin
              r_block[9'd511 - {r_ptr, 3'b000} -: 8] <= s_data;
              r_ptr <= r_ptr + 6'd1;
              r_cnt <= r_cnt + LEN_W'(1);
              if (r_ptr == 6'd63 && s_last) r_pad_pending <= 1'b1;
            end
          end
        end
        S_PAD: begin
          r_block <= w_pad_block;
          if (r_ptr <= 6'd55) r_final       <= 1'b1;
          else                r_len_pending <= 1'b1;
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_init  <= r_first;
            r_next  <= !r_first;
            r_first <= 1'b0;
          end
        end
        S_WAIT: begin
          if (w_digest) begin
            if (r_pad_pending) begin
              r_block       <= {8'h80, 440'd0, w_len};
              r_pad_pending <= 1'b0;
              r_final       <= 1'b1;
            end else if (r_len_pending) begin
              r_block       <= {448'd0, w_len};
              r_len_pending <= 1'b0;
              r_final       <= 1'b1;
            end else if (r_final) begin
              r_done  <= 1'b1;
              r_cnt   <= '0;
              r_ptr   <= '0;
              r_first <= 1'b1;
              r_final <= 1'b0;
            end else begin
              r_ptr <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_PADDER_BLKCNT_EN
  logic [15:0] r_blk_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_blk_cnt <= '0;
    else if (r_done)  r_blk_cnt <= '0;
    else if (w_issue) r_blk_cnt <= r_blk_cnt + 16'd1;
  end
  assign blk_cnt = r_blk_cnt;
`endif

  assign core_init  = r_init;
  assign core_next  = r_next;
  assign core_mode  = r_mode;
  assign core_block = r_block;
  assign msg_done   = r_done;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: randomized byte messages, a simple core model, and a padding
// reference built from plain byte-queue arithmetic.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         mode = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_data = 8'h00;
  logic         s_last = 1'b0;
  logic         s_empty = 1'b0;
  logic         core_ready;
  logic         core_init;
  logic         core_next;
  logic         core_mode;
  logic [511:0] core_block;
  logic         core_digest_valid = 1'b0;
  logic         msg_done;
  logic         core_idle = 1'b1;
  logic         hold_ready = 1'b0;
`ifdef SHA256_PADDER_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  assign core_ready = core_idle && !hold_ready;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_empty(s_empty),
    .core_ready(core_ready), .core_init(core_init), .core_next(core_next), .core_mode(core_mode),
    .core_block(core_block), .core_digest_valid(core_digest_valid), .msg_done(msg_done)
`ifdef SHA256_PADDER_BLKCNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass = 0;
  int           pulse_cnt = 0;
  int           done_cnt = 0;
  logic [511:0] exp_q[$];
  bit           exp_kind_q[$];
  bit           exp_mode_q[$];
  bit           exp_fin_q[$];
  logic [7:0]   msg_b[$];
  logic [511:0] last_blk = '0;
  bit           prev_ready = 1'b0;
  bit           done_chk = 1'b0;
  bit           done_exp = 1'b0;
  int           blk_idx = 0;
  logic [511:0] m_blk;
  logic [511:0] m_cap;
  bit           m_kind;
  bit           m_md;
  bit           m_fin;
  int           m_lat;

  // Core model and block scoreboard: sampled on the falling edge.
  always begin
    @(negedge clk);
    if (!reset_n) begin
      core_digest_valid = 1'b0;
      core_idle = 1'b1;
      prev_ready = 1'b0;
      done_chk = 1'b0;
      blk_idx = 0;
    end else begin
      if (done_chk) begin
        done_chk = 1'b0;
        n_checks++;
        if (msg_done !== done_exp) $display("FAIL done_timing: msg_done=%0b want %0b", msg_done, done_exp);
        else n_pass++;
      end
      if (core_init || core_next) begin
        pulse_cnt++;
        last_blk = core_block;
        n_checks++;
        if (!prev_ready) $display("FAIL issue_not_ready: pulse while core_ready=0");
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pulse: init=%0b next=%0b with no expected block", core_init, core_next);
          m_fin = 1'b1;
        end else begin
          m_blk = exp_q.pop_front();
          m_kind = exp_kind_q.pop_front();
          m_md = exp_mode_q.pop_front();
          m_fin = exp_fin_q.pop_front();
          if (core_block !== m_blk || {core_init, core_next} !== {m_kind, !m_kind} || core_mode !== m_md)
            $display("FAIL block: init/next/mode=%0b%0b%0b want %0b%0b%0b got %h want %h",
                     core_init, core_next, core_mode, m_kind, !m_kind, m_md, core_block, m_blk);
          else n_pass++;
`ifdef SHA256_PADDER_BLKCNT_EN
          blk_idx = m_kind ? 1 : blk_idx + 1;
          n_checks++;
          if (blk_cnt !== 16'(blk_idx)) $display("FAIL blk_cnt: got %0d want %0d", blk_cnt, blk_idx);
          else n_pass++;
`endif
        end
        m_cap = core_block;
        @(posedge clk); #1;
        core_digest_valid = 1'b0;
        core_idle = 1'b0;
        m_lat = $urandom_range(1, 6);
        repeat (m_lat) @(negedge clk);
        n_checks++;
        if (core_block !== m_cap) $display("FAIL block_unstable: got %h want %h", core_block, m_cap);
        else n_pass++;
        core_digest_valid = 1'b1;
        core_idle = 1'b1;
        done_chk = 1'b1;
        done_exp = m_fin;
      end
      prev_ready = core_ready;
    end
  end

  always @(negedge clk) if (reset_n && msg_done) done_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference padding: bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic model_push(input int n, input bit md);
    logic [7:0]   p[$];
    logic [63:0]  len;
    logic [511:0] blk;
    int           nb;
    p = msg_b;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[b*64+i];
      exp_q.push_back(blk);
      exp_kind_q.push_back(b == 0);
      exp_mode_q.push_back(md);
      exp_fin_q.push_back(b == nb - 1);
    end
  endtask

  task automatic fill_rand(input int n, input bit zeros);
    msg_b.delete();
    for (int i = 0; i < n; i++) msg_b.push_back(zeros ? 8'h00 : 8'($urandom));
  endtask

  task automatic beat(input logic [7:0] d, input bit last, input bit emp, input bit md);
    int t;
    t = 0;
    if ($urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1; s_data = d; s_last = last; s_empty = emp; mode = md;
    while (!s_ready && t < 3000) begin @(posedge clk); #1; t++; end
    if (!s_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles", t);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; mode = 1'($urandom);
  endtask

  task automatic drive_msg(input int n, input bit md, input bit do_last);
    if (n == 0 && do_last) beat(8'($urandom), 1'b1, 1'b1, md);
    else for (int i = 0; i < n; i++) beat(msg_b[i], do_last && (i == n - 1), 1'b0, (i == 0) ? md : 1'($urandom));
  endtask

  task automatic wait_done(input int target, input string name);
    int t;
    t = 0;
    while (done_cnt < target && t < 5000) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (done_cnt < target) $display("FAIL %s: msg_done count %0d want %0d", name, done_cnt, target);
    else n_pass++;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %0b want 1", s_ready); else n_pass++;
    n_checks++; if (core_init !== 1'b0) $display("FAIL reset_init: got %0b want 0", core_init); else n_pass++;
    n_checks++; if (core_next !== 1'b0) $display("FAIL reset_next: got %0b want 0", core_next); else n_pass++;
    n_checks++; if (msg_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", msg_done); else n_pass++;
    n_checks++; if (core_mode !== 1'b0) $display("FAIL reset_mode: got %0b want 0", core_mode); else n_pass++;
    n_checks++; if (core_block !== 512'd0) $display("FAIL reset_block: got %h want 0", core_block); else n_pass++;
`ifdef SHA256_PADDER_BLKCNT_EN
    n_checks++; if (blk_cnt !== 16'd0) $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt); else n_pass++;
`endif
    reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_abc;
    int p0, d0;
    logic [511:0] want;
    want = {24'h616263, 8'h80, 416'h0, 64'h18};
    p0 = pulse_cnt; d0 = done_cnt;
    msg_b.delete();
    msg_b.push_back(8'h61); msg_b.push_back(8'h62); msg_b.push_back(8'h63);
    model_push(3, 1'b1);
    drive_msg(3, 1'b1, 1'b1);
    wait_done(d0 + 1, "abc_done");
    n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL abc_pulses: got %0d want 1", pulse_cnt - p0); else n_pass++;
    n_checks++; if (last_blk !== want) $display("FAIL abc_block: got %h want %h", last_blk, want); else n_pass++;
    n_checks++; if (core_mode !== 1'b1) $display("FAIL abc_mode: got %0b want 1", core_mode); else n_pass++;
  endtask

  task automatic test_len55;
    int p0, d0;
    p0 = pulse_cnt; d0 = done_cnt;
    fill_rand(55, 1'b1);
    model_push(55, 1'b0);
    drive_msg(55, 1'b0, 1'b1);
    wait_done(d0 + 1, "len55_done");
    n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL len55_pulses: got %0d want 1", pulse_cnt - p0); else n_pass++;
    n_checks++; if (last_blk[63:0] !== 64'h1b8) $display("FAIL len55_len: got %h want 1b8", last_blk[63:0]); else n_pass++;
    n_checks++; if (last_blk[71:64] !== 8'h80) $display("FAIL len55_pad: got %h want 80", last_blk[71:64]); else n_pass++;
  endtask

  task automatic test_len56;
    int p0, d0;
    p0 = pulse_cnt; d0 = done_cnt;
    fill_rand(56, 1'b0);
    model_push(56, 1'b1);
    drive_msg(56, 1'b1, 1'b1);
    wait_done(d0 + 1, "len56_done");
    n_checks++; if (pulse_cnt - p0 !== 2) $display("FAIL len56_pulses: got %0d want 2", pulse_cnt - p0); else n_pass++;
    n_checks++; if (last_blk !== {448'h0, 64'h1c0}) $display("FAIL len56_blk1: got %h", last_blk); else n_pass++;
  endtask

  task automatic test_len64;
    int p0, d0;
    p0 = pulse_cnt; d0 = done_cnt;
    fill_rand(64, 1'b0);
    model_push(64, 1'b0);
    drive_msg(64, 1'b0, 1'b1);
    wait_done(d0 + 1, "len64_done");
    n_checks++; if (pulse_cnt - p0 !== 2) $display("FAIL len64_pulses: got %0d want 2", pulse_cnt - p0); else n_pass++;
    n_checks++; if (last_blk !== {8'h80, 440'h0, 64'h200}) $display("FAIL len64_blk1: got %h", last_blk); else n_pass++;
  endtask

  task automatic test_empty;
    int p0, d0;
    p0 = pulse_cnt; d0 = done_cnt;
    msg_b.delete();
    model_push(0, 1'b1);
    drive_msg(0, 1'b1, 1'b1);
    wait_done(d0 + 1, "empty_done");
    n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL empty_pulses: got %0d want 1", pulse_cnt - p0); else n_pass++;
    n_checks++; if (last_blk !== {8'h80, 504'h0}) $display("FAIL empty_block: got %h", last_blk); else n_pass++;
    n_checks++; if (core_mode !== 1'b1) $display("FAIL empty_mode: got %0b want 1", core_mode); else n_pass++;
  endtask

  task automatic test_stall;
    int p0, d0;
    bit bad;
    logic [511:0] snap;
    p0 = pulse_cnt; d0 = done_cnt;
    hold_ready = 1'b1;
    msg_b.delete();
    msg_b.push_back(8'h61); msg_b.push_back(8'h62); msg_b.push_back(8'h63);
    model_push(3, 1'b0);
    drive_msg(3, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    snap = core_block;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (core_init || core_next || s_ready) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL stall_quiet: pulse or s_ready seen while core_ready=0"); else n_pass++;
    n_checks++; if (core_block !== snap) $display("FAIL stall_block: got %h want %h", core_block, snap); else n_pass++;
    n_checks++; if (pulse_cnt !== p0) $display("FAIL stall_pulses: got %0d want %0d", pulse_cnt, p0); else n_pass++;
    hold_ready = 1'b0;
    wait_done(d0 + 1, "stall_done");
    n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL stall_after: got %0d want 1", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_boundaries;
    int lens[10];
    int d0;
    lens = '{1, 54, 57, 63, 65, 119, 120, 127, 128, 129};
    for (int k = 0; k < 10; k++) begin
      d0 = done_cnt;
      fill_rand(lens[k], 1'b0);
      model_push(lens[k], 1'($urandom));
      drive_msg(lens[k], exp_mode_q[exp_mode_q.size()-1], 1'b1);
      wait_done(d0 + 1, "boundary_done");
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL boundary_left: %0d blocks never issued", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_fill;
    int p0;
    p0 = pulse_cnt;
    fill_rand(10, 1'b0);
    drive_msg(10, 1'b1, 1'b0);
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (s_ready !== 1'b1) $display("FAIL midreset_s_ready: got %0b want 1", s_ready); else n_pass++;
    n_checks++; if (core_block !== 512'd0) $display("FAIL midreset_block: got %h want 0", core_block); else n_pass++;
    n_checks++; if (pulse_cnt !== p0) $display("FAIL midreset_pulses: got %0d want %0d", pulse_cnt, p0); else n_pass++;
    n_checks++; if (msg_done !== 1'b0) $display("FAIL midreset_done: got %0b want 0", msg_done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int d0, n;
    bit md;
    d0 = done_cnt;
    for (int m = 0; m < 8; m++) begin
      n = (m == 0) ? 5 : $urandom_range(0, 140);
      md = 1'($urandom);
      fill_rand(n, 1'b0);
      model_push(n, md);
      drive_msg(n, md, 1'b1);
    end
    wait_done(d0 + 8, "b2b_done");
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_left: %0d blocks never issued", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_abc;
    test_len55;
    test_len56;
    test_len64;
    test_empty;
    test_stall;
    test_boundaries;
    test_reset_mid_fill;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
